// File: rtl/shr_6sipo_if.sv
// Bus bundle for the 6-bit SIPO receiver: serial input side plus the word output handshake.
// The master drives the serial stream and TAKE/CLR; the slave is the receiver.
interface shr_6sipo_if;
  logic       EN;
  logic       DIN;
  logic       SYNC;
  logic       TAKE;
  logic       CLR;
  logic [5:0] DOUT;
  logic       VALID;
  logic       OVR;
  logic       ABORT;
  logic       PERR;

  modport master (
    output EN, DIN, SYNC, TAKE, CLR,
    input  DOUT, VALID, OVR, ABORT, PERR
  );

  modport slave (
    input  EN, DIN, SYNC, TAKE, CLR,
    output DOUT, VALID, OVR, ABORT, PERR
  );
endinterface

// File: rtl/shr_6sipo.sv
// 6-bit LSB-first serial-to-parallel receiver with VALID/TAKE output buffer, overrun, resync and stall timeout.
// Optional odd-parity framing is enabled by defining SHR_6SIPO_PARITY_EN.
module shr_6sipo #(
  parameter int TIMEOUT = 15
) (
  input logic        CLK,
  input logic        RST,
  shr_6sipo_if.slave bus
);

  localparam int            IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDL_LAST = IW'(TIMEOUT - 1);

`ifdef SHR_6SIPO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_PAR = 2'd2} state_t;

  // Odd parity: the data bits and the parity bit must XOR to 1, otherwise flag an error.
  function automatic logic odd_par_err(input logic [5:0] data, input logic par);
    odd_par_err = ~(^{data, par});
  endfunction
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [5:0]    sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [IW-1:0] idl_q, idl_d;
  logic [5:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          abort_q, abort_d;
  logic          done_s;
  logic [5:0]    word_s;
`ifdef SHR_6SIPO_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_s;
`endif

  // Next-state: frame assembly, resync, stall timeout and output buffer update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    idl_d   = idl_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    abort_d = 1'b0;
    done_s  = 1'b0;
    word_s  = sr_q;
`ifdef SHR_6SIPO_PARITY_EN
    perr_d  = perr_q;
    par_s   = 1'b0;
`endif

    if (bus.EN) begin
      idl_d = {IW{1'b0}};
      sr_d  = {bus.DIN, sr_q[5:1]};
      // SYNC restarts the frame from any state; the shifted-in bit is bit 0 either way.
      if ((state_q == S_IDLE) || bus.SYNC) begin
        state_d = S_RECV;
        cnt_d   = 3'd1;
      end else if (state_q == S_RECV) begin
        if (cnt_q == 3'd5) begin
          cnt_d = 3'd0;
`ifdef SHR_6SIPO_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_IDLE;
          done_s  = 1'b1;
          word_s  = {bus.DIN, sr_q[5:1]};
`endif
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
`ifdef SHR_6SIPO_PARITY_EN
      else if (state_q == S_PAR) begin
        sr_d    = sr_q;
        state_d = S_IDLE;
        done_s  = 1'b1;
        word_s  = sr_q;
        par_s   = bus.DIN;
      end
`endif
      else begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    end else if (state_q != S_IDLE) begin
      if (idl_q == IDL_LAST) begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        idl_d   = {IW{1'b0}};
        abort_d = 1'b1;
      end else begin
        idl_d = idl_q + IW'(1);
      end
    end else begin
      idl_d = {IW{1'b0}};
    end

    if (bus.CLR) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    // A new overrun is applied after CLR so it wins when both happen together.
    if (done_s) begin
      if (!valid_q || bus.TAKE) begin
        dout_d  = word_s;
        valid_d = 1'b1;
`ifdef SHR_6SIPO_PARITY_EN
        perr_d  = odd_par_err(word_s, par_s);
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bus.TAKE && valid_q) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sr_q    <= 6'd0;
      cnt_q   <= 3'd0;
      idl_q   <= {IW{1'b0}};
      dout_q  <= 6'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
`ifdef SHR_6SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      idl_q   <= idl_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
`ifdef SHR_6SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.DOUT  = dout_q;
  assign bus.VALID = valid_q;
  assign bus.OVR   = ovr_q;
  assign bus.ABORT = abort_q;
`ifdef SHR_6SIPO_PARITY_EN
  assign bus.PERR  = perr_q;
`else
  assign bus.PERR  = 1'b0;
`endif

endmodule

// File: tb/tb_shr_6sipo.sv
// Directed bench for shr_6sipo: word assembly, back-to-back take, overrun/CLR, timeout, resync, reset.
// Parity cases are included when SHR_6SIPO_PARITY_EN is defined.
module tb_shr_6sipo;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;
  logic vall;

`ifdef SHR_6SIPO_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  always #5 CLK = ~CLK;

  shr_6sipo_if bus ();

  shr_6sipo #(.TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs read here reflect the previous rising edge.
  task automatic tick(input logic en, input logic din, input logic sync, input logic take, input logic clr);
    @(negedge CLK);
    bus.EN   = en;
    bus.DIN  = din;
    bus.SYNC = sync;
    bus.TAKE = take;
    bus.CLR  = clr;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends one frame (plus correct odd parity in the parity build); vall is VALID ANDed over every tick.
  task automatic send_word(input logic [5:0] w, input logic sync_first, input logic take_last,
                           output logic v_all);
    v_all = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, w[i], sync_first && (i == 0), take_last && (i == 5) && !PAR_BUILD, 1'b0);
      v_all = v_all & bus.VALID;
    end
    if (PAR_BUILD) begin
      tick(1'b1, ~(^w), 1'b0, take_last, 1'b0);
      v_all = v_all & bus.VALID;
    end
  endtask

  initial begin
    RST      = 1'b0;
    bus.EN   = 1'b0;
    bus.DIN  = 1'b0;
    bus.SYNC = 1'b0;
    bus.TAKE = 1'b0;
    bus.CLR  = 1'b0;
    #12;
    check("rst_dout", bus.DOUT, 8'h00);
    check("rst_valid", bus.VALID, 8'h00);
    check("rst_ovr", bus.OVR, 8'h00);
    check("rst_abort", bus.ABORT, 8'h00);
    check("rst_perr", bus.PERR, 8'h00);
    @(negedge CLK);
    RST = 1'b1;

    // Single word 1,0,1,1,0,1 LSB first
    send_word(6'h2D, 1'b0, 1'b0, vall);
    idle();
    check("w1_dout", bus.DOUT, 8'h2D);
    check("w1_valid", bus.VALID, 8'h01);
    check("w1_ovr", bus.OVR, 8'h00);
    check("w1_abort", bus.ABORT, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("take_valid", bus.VALID, 8'h00);
    check("take_dout_hold", bus.DOUT, 8'h2D);

    // Back-to-back with TAKE on completion of the second word
    send_word(6'h2D, 1'b0, 1'b0, vall);
    send_word(6'h12, 1'b0, 1'b1, vall);
    check("b2b_nogap", vall, 8'h01);
    idle();
    check("b2b_dout", bus.DOUT, 8'h12);
    check("b2b_valid", bus.VALID, 8'h01);
    check("b2b_ovr", bus.OVR, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Overrun, then CLR
    send_word(6'h2D, 1'b0, 1'b0, vall);
    send_word(6'h12, 1'b0, 1'b0, vall);
    idle();
    check("ovr_dout", bus.DOUT, 8'h2D);
    check("ovr_set", bus.OVR, 8'h01);
    check("ovr_valid", bus.VALID, 8'h01);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("clr_ovr", bus.OVR, 8'h00);
    check("clr_valid", bus.VALID, 8'h01);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("ovr_take_valid", bus.VALID, 8'h00);

    // Stall timeout after three bits
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      idle();
      if (k == 15) check("to_abort_early", bus.ABORT, 8'h00);
      if (k == 16) begin
        check("to_abort_pulse", bus.ABORT, 8'h01);
        check("to_valid", bus.VALID, 8'h00);
        check("to_dout", bus.DOUT, 8'h2D);
      end
      if (k == 17) check("to_abort_end", bus.ABORT, 8'h00);
    end
    send_word(6'h3F, 1'b0, 1'b0, vall);
    idle();
    check("to_next_dout", bus.DOUT, 8'h3F);
    check("to_next_valid", bus.VALID, 8'h01);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Resync: four bits, then SYNC restarts the frame
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(6'h08, 1'b1, 1'b0, vall);
    idle();
    check("sync_dout", bus.DOUT, 8'h08);
    check("sync_valid", bus.VALID, 8'h01);
    check("sync_abort", bus.ABORT, 8'h00);

    // Reset pulsed during bit 3 of a partial frame
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("mrst_dout", bus.DOUT, 8'h00);
    check("mrst_valid", bus.VALID, 8'h00);
    check("mrst_ovr", bus.OVR, 8'h00);
    check("mrst_abort", bus.ABORT, 8'h00);
    check("mrst_perr", bus.PERR, 8'h00);
    @(negedge CLK);
    bus.EN = 1'b0;
    RST    = 1'b1;
    send_word(6'h15, 1'b0, 1'b0, vall);
    idle();
    check("mrst_next_dout", bus.DOUT, 8'h15);
    check("mrst_next_valid", bus.VALID, 8'h01);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

`ifdef SHR_6SIPO_PARITY_EN
    // Good parity (1) and bad parity (0) after 6'h2D
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) tick(1'b1, ((6'h2D >> i) & 6'h01) != 6'h00, 1'b0, 1'b0, 1'b0);
      tick(1'b1, (p == 0), 1'b0, 1'b0, 1'b0);
      check("par_valid_pre", bus.VALID, 8'h00);
      idle();
      check("par_valid", bus.VALID, 8'h01);
      check("par_dout", bus.DOUT, 8'h2D);
      check("par_perr", bus.PERR, (p == 0) ? 8'h00 : 8'h01);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
